iir_main: RTL and testbench
===========================

# iir_main

Fixed-point, fourth-order IIR filter: two cascaded second-order (biquad) sections, direct form I, one 32-bit signed sample per clock. It sits in the audio datapath as a streaming filter with no handshake. It accepts one input sample every rising clock edge and produces one filtered sample per edge. Coefficients are compile-time parameters.

## Interface
- `COEF_W`, 32: coefficient width, signed.
- `FRAC`, 30: fractional bits of coefficients (Q2.30, range [-2, 2)).
- `S1_B0`, `S1_B1`, `S1_B2`, `S1_A1`, `S1_A2`: section-1 coefficients. Defaults are `32'sh4000_0000` (1.0), 0, 0, 0, 0.
- `S2_B0`, `S2_B1`, `S2_B2`, `S2_A1`, `S2_A2`: section-2 coefficients, same defaults as section 1.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `reset` input, 1 bit: reset is synchronous and active-high.
- `in` input, 32 bits signed: input sample, sampled every rising edge.
- `out` output, 32 bits signed: filtered sample, registered.

## Operation
- Each section computes `y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] − A1·y[n-1] − A2·y[n-2]`.
- Section 1 input is `in`. Section 2 input is section 1's registered output. `out` is section 2's registered output.
- Products are full 64-bit signed. Products are summed in a 67-bit accumulator with no intermediate truncation.
- Rounding: add `2^(FRAC-1)`, then arithmetic right shift by `FRAC` (round half up).
- Narrowing to 32 bits is controlled by `IIR_MAIN_SAT_EN` (see Configuration).
- The feedback history `y[n-1]` and `y[n-2]` holds the section's own narrowed 32-bit output.
- Each section keeps 4 history registers: x1, x2, y1, y2.
- There is no state machine, no valid signal and no stall. Every edge with `reset` low advances the filter by one sample.

## Timing
- Reset: on a rising edge with `reset` high, all history registers, both section outputs and `out` go to 0. `in` is ignored on that edge.
- Latency with identity coefficients is 2 edges:
  - edge t samples `in` into section 1;
  - edge t+1 updates section 2;
  - `out` is valid after edge t+1 and is stable for the whole following cycle.
- Throughput is one sample per clock.
- Reset mid-stream: all history is cleared. The first output after reset depends only on samples taken after reset deasserts. There is no residual pipeline data.
- `reset` held high for several cycles keeps `out` at 0.

## Configuration
- `IIR_MAIN_SAT_EN` defined: each section's rounded sum saturates to [`32'sh8000_0000`, `32'sh7FFF_FFFF`] before it is registered and fed back.
- `IIR_MAIN_SAT_EN` undefined: keep the low 32 bits of the rounded sum (two's-complement wrap). No extra logic.

## Structure
- Package `iir_pkg`:
  - `COEF_W`, `FRAC`, sample width (32), accumulator width (67);
  - the `sample_t` typedef;
  - the identity-coefficient constant `COEF_ONE = 32'sh4000_0000`.
- Sub-module `iir_biquad`:
  - one section, parameterised by B0–B2, A1, A2;
  - ports: clk, reset, x in, y out (registered);
  - instantiated twice in `iir_main`.
- The round/saturate logic lives inside `iir_biquad`, under the macro.

## Test plan
1. Reset hold: `reset` high for 3 cycles with `in = 32'sh7FFF_FFFF` → `out = 0` on every cycle. After release with `in = 0`, `out` stays 0.
2. Default coefficients, impulse: `in = 1000` for one cycle, then 0 → `out = 1000` exactly 2 edges later, 0 on all other cycles.
3. Parameters `S1_B0 = 32'sh2000_0000` (0.5), `S1_A1 = 32'shE000_0000` (−0.5), section 2 identity.
   - Stimulus: step `in = 1024`.
   - Required `out` sequence: 512, 768, 896, 960, 992 … converging to 1024.
4. Rounding, with `S1_B0 = 0.5`, section 2 identity.
   - `in = 3` → `out = 2`.
   - `in = −3` → `out = −1`.
5. Overflow, with `S1_B0 = 32'sh7FFF_FFFF`.
   - Stimulus: `in = 32'sh7000_0000`.
   - With `IIR_MAIN_SAT_EN`: `out = 32'sh7FFF_FFFF`.
   - Without it: `out` is the wrapped negative value.
6. Mid-stream reset: during scenario 3, assert `reset` for one edge.
   - `out` is 0 after that edge propagates.
   - The step response then restarts at 512, 768, ….

Source files
------------

// File: rtl/iir_pkg.sv
// Shared widths, sample type and coefficient constants for the iir_main
// fourth-order fixed-point IIR filter.
package iir_pkg;

  localparam int COEF_W   = 32;
  localparam int FRAC     = 30;
  localparam int SAMPLE_W = 32;
  localparam int ACC_W    = 67;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam logic signed [COEF_W-1:0] COEF_ONE  = 32'sh4000_0000;
  localparam logic signed [COEF_W-1:0] COEF_ZERO = 32'sd0;

  localparam sample_t SAMPLE_MAX  = 32'sh7FFF_FFFF;
  localparam sample_t SAMPLE_MIN  = 32'sh8000_0000;
  localparam sample_t SAMPLE_ZERO = 32'sd0;

endpackage

// File: rtl/iir_biquad.sv
// One direct-form-I biquad section: full-precision multiply-accumulate, round
// half up, then narrow (saturate when IIR_MAIN_SAT_EN is defined, else wrap).
module iir_biquad
  import iir_pkg::*;
#(
  parameter int                          COEF_BITS = 32,
  parameter int                          FRAC_BITS = 30,
  parameter logic signed [COEF_BITS-1:0] B0 = COEF_ONE,
  parameter logic signed [COEF_BITS-1:0] B1 = COEF_ZERO,
  parameter logic signed [COEF_BITS-1:0] B2 = COEF_ZERO,
  parameter logic signed [COEF_BITS-1:0] A1 = COEF_ZERO,
  parameter logic signed [COEF_BITS-1:0] A2 = COEF_ZERO
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [SAMPLE_W-1:0]  x,
  output logic signed [SAMPLE_W-1:0]  y
);

  localparam int PROD_W = COEF_BITS + SAMPLE_W;
  localparam logic signed [ACC_W-1:0] HALF_LSB =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  sample_t x1_r, x2_r, y1_r, y2_r;
  sample_t y_next_s;
  logic signed [PROD_W-1:0] p_b0_s, p_b1_s, p_b2_s, p_a1_s, p_a2_s;
  logic signed [ACC_W-1:0]  acc_s, rnd_s;

  function automatic sample_t narrow(input logic signed [ACC_W-1:0] v);
`ifdef IIR_MAIN_SAT_EN
    if (v > ACC_W'(SAMPLE_MAX)) begin
      narrow = SAMPLE_MAX;
    end else if (v < ACC_W'(SAMPLE_MIN)) begin
      narrow = SAMPLE_MIN;
    end else begin
      narrow = sample_t'(v);
    end
`else
    narrow = sample_t'(v);
`endif
  endfunction

  // Exact products and sum; the feedback terms enter with a negative sign.
  always_comb begin
    p_b0_s   = PROD_W'(B0) * PROD_W'(x);
    p_b1_s   = PROD_W'(B1) * PROD_W'(x1_r);
    p_b2_s   = PROD_W'(B2) * PROD_W'(x2_r);
    p_a1_s   = PROD_W'(A1) * PROD_W'(y1_r);
    p_a2_s   = PROD_W'(A2) * PROD_W'(y2_r);
    acc_s    = ACC_W'(p_b0_s) + ACC_W'(p_b1_s) + ACC_W'(p_b2_s)
             - ACC_W'(p_a1_s) - ACC_W'(p_a2_s);
    rnd_s    = (acc_s + HALF_LSB) >>> FRAC_BITS;
    y_next_s = narrow(rnd_s);
  end

  // History shift; y1_r doubles as the section's registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      x1_r <= SAMPLE_ZERO;
      x2_r <= SAMPLE_ZERO;
      y1_r <= SAMPLE_ZERO;
      y2_r <= SAMPLE_ZERO;
    end else begin
      x1_r <= x;
      x2_r <= x1_r;
      y1_r <= y_next_s;
      y2_r <= y1_r;
    end
  end

  assign y = y1_r;

endmodule

// File: rtl/iir_main.sv
// Fourth-order streaming IIR filter: two cascaded biquads, one sample per clock.
// Optional macro IIR_MAIN_SAT_EN selects saturation instead of wrap on narrowing.
module iir_main #(
  parameter int                       COEF_W = 32,
  parameter int                       FRAC   = 30,
  parameter logic signed [COEF_W-1:0] S1_B0  = 32'sh4000_0000,
  parameter logic signed [COEF_W-1:0] S1_B1  = 32'sd0,
  parameter logic signed [COEF_W-1:0] S1_B2  = 32'sd0,
  parameter logic signed [COEF_W-1:0] S1_A1  = 32'sd0,
  parameter logic signed [COEF_W-1:0] S1_A2  = 32'sd0,
  parameter logic signed [COEF_W-1:0] S2_B0  = 32'sh4000_0000,
  parameter logic signed [COEF_W-1:0] S2_B1  = 32'sd0,
  parameter logic signed [COEF_W-1:0] S2_B2  = 32'sd0,
  parameter logic signed [COEF_W-1:0] S2_A1  = 32'sd0,
  parameter logic signed [COEF_W-1:0] S2_A2  = 32'sd0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic signed [iir_pkg::SAMPLE_W-1:0] in,
  output logic signed [iir_pkg::SAMPLE_W-1:0] out
);

  import iir_pkg::*;

  sample_t s1_y_s;

  iir_biquad #(
    .COEF_BITS (COEF_W),
    .FRAC_BITS (FRAC),
    .B0 (S1_B0), .B1 (S1_B1), .B2 (S1_B2), .A1 (S1_A1), .A2 (S1_A2)
  ) u_sec1 (
    .clk   (clk),
    .reset (reset),
    .x     (in),
    .y     (s1_y_s)
  );

  // Section 2 consumes section 1's registered output, giving two-edge latency.
  iir_biquad #(
    .COEF_BITS (COEF_W),
    .FRAC_BITS (FRAC),
    .B0 (S2_B0), .B1 (S2_B1), .B2 (S2_B2), .A1 (S2_A1), .A2 (S2_A2)
  ) u_sec2 (
    .clk   (clk),
    .reset (reset),
    .x     (s1_y_s),
    .y     (out)
  );

endmodule

// File: tb/tb_iir_main.sv
// Scoreboard bench for iir_main: five filter configurations share one input
// stream and are checked every cycle against a wide-arithmetic reference.
module tb_iir_main;

  typedef logic signed [31:0] smp_t;

  localparam int NDUT    = 5;
  localparam int FRAC_TB = 30;

  localparam smp_t ONE     = 32'sh4000_0000;
  localparam smp_t HALF    = 32'sh2000_0000;
  localparam smp_t NHALF   = 32'shE000_0000;
  localparam smp_t QTR     = 32'sh1000_0000;
  localparam smp_t NQTR    = 32'shF000_0000;
  localparam smp_t EIGHTH  = 32'sh0800_0000;
  localparam smp_t NEIGHTH = 32'shF800_0000;
  localparam smp_t MAXC    = 32'sh7FFF_FFFF;
  localparam smp_t ZERO    = 32'sd0;

  logic clk = 1'b0;
  logic reset;
  smp_t in;
  smp_t out_id, out_lp, out_half, out_ovf, out_mix;
  smp_t dut_out [NDUT];

  int vectors = 0;
  int miscompares = 0;

  smp_t exp_q [$];
  smp_t cf  [NDUT][2][5];
  smp_t hx1 [NDUT][2];
  smp_t hx2 [NDUT][2];
  smp_t hy1 [NDUT][2];
  smp_t hy2 [NDUT][2];
  string nm [NDUT] = '{"identity", "lowpass", "half", "overflow", "mixed"};

  always #5 clk = ~clk;

  iir_main dut_id (.clk(clk), .reset(reset), .in(in), .out(out_id));
  iir_main #(.S1_B0(HALF), .S1_A1(NHALF))
    dut_lp (.clk(clk), .reset(reset), .in(in), .out(out_lp));
  iir_main #(.S1_B0(HALF))
    dut_half (.clk(clk), .reset(reset), .in(in), .out(out_half));
  iir_main #(.S1_B0(MAXC))
    dut_ovf (.clk(clk), .reset(reset), .in(in), .out(out_ovf));
  iir_main #(.S1_B0(QTR), .S1_B1(HALF), .S1_B2(QTR), .S1_A1(NHALF), .S1_A2(EIGHTH),
             .S2_B0(HALF), .S2_B1(NQTR), .S2_B2(EIGHTH), .S2_A1(QTR), .S2_A2(NEIGHTH))
    dut_mix (.clk(clk), .reset(reset), .in(in), .out(out_mix));

  assign dut_out[0] = out_id;
  assign dut_out[1] = out_lp;
  assign dut_out[2] = out_half;
  assign dut_out[3] = out_ovf;
  assign dut_out[4] = out_mix;

  function automatic logic signed [127:0] wide(input smp_t v);
    wide = v;
  endfunction

  function automatic smp_t narrow(input logic signed [127:0] v);
`ifdef IIR_MAIN_SAT_EN
    if (v > 128'sd2147483647) return 32'sh7FFF_FFFF;
    if (v < -128'sd2147483648) return 32'sh8000_0000;
`endif
    return v[31:0];
  endfunction

  // y = B0 x + B1 x[n-1] + B2 x[n-2] - A1 y[n-1] - A2 y[n-2], rounded half up.
  function automatic smp_t sec_out(input int d, input int s, input smp_t x);
    logic signed [127:0] acc;
    acc = wide(cf[d][s][0]) * wide(x)
        + wide(cf[d][s][1]) * wide(hx1[d][s])
        + wide(cf[d][s][2]) * wide(hx2[d][s])
        - wide(cf[d][s][3]) * wide(hy1[d][s])
        - wide(cf[d][s][4]) * wide(hy2[d][s]);
    acc = (acc + (128'sd1 <<< (FRAC_TB - 1))) >>> FRAC_TB;
    return narrow(acc);
  endfunction

  task automatic advance(input int d, input int s, input smp_t x, input smp_t y);
    hx2[d][s] = hx1[d][s];
    hx1[d][s] = x;
    hy2[d][s] = hy1[d][s];
    hy1[d][s] = y;
  endtask

  task automatic clear_hist();
    for (int d = 0; d < NDUT; d++) begin
      for (int s = 0; s < 2; s++) begin
        hx1[d][s] = ZERO; hx2[d][s] = ZERO; hy1[d][s] = ZERO; hy2[d][s] = ZERO;
      end
    end
  endtask

  task automatic set_cf(input int d, input int s, input smp_t b0, input smp_t b1,
                        input smp_t b2, input smp_t a1, input smp_t a2);
    cf[d][s][0] = b0; cf[d][s][1] = b1; cf[d][s][2] = b2;
    cf[d][s][3] = a1; cf[d][s][4] = a2;
  endtask

  // Drive one sample, advance the reference, queue the output due after the edge.
  task automatic step(input logic rst, input smp_t x);
    smp_t s1n, s2n;
    reset = rst;
    in    = x;
    if (rst) clear_hist();
    for (int d = 0; d < NDUT; d++) begin
      if (!rst) begin
        s2n = sec_out(d, 1, hy1[d][0]);
        s1n = sec_out(d, 0, x);
        advance(d, 1, hy1[d][0], s2n);
        advance(d, 0, x, s1n);
      end
      exp_q.push_back(hy1[d][1]);
    end
    @(negedge clk);
  endtask

  // Monitor: one output set per cycle, sampled just after the rising edge.
  initial begin
    smp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() >= NDUT) begin
        for (int d = 0; d < NDUT; d++) begin
          e = exp_q.pop_front();
          vectors++;
          if (dut_out[d] !== e) begin
            miscompares++;
            $display("FAIL %s out at %0t: got %0d, expected %0d", nm[d], $time, dut_out[d], e);
          end
        end
      end
    end
  end

  initial begin
    int   r;
    smp_t v;
    for (int s = 0; s < 2; s++) begin
      set_cf(0, s, ONE, ZERO, ZERO, ZERO, ZERO);
      set_cf(1, s, ONE, ZERO, ZERO, ZERO, ZERO);
      set_cf(2, s, ONE, ZERO, ZERO, ZERO, ZERO);
      set_cf(3, s, ONE, ZERO, ZERO, ZERO, ZERO);
    end
    set_cf(1, 0, HALF, ZERO, ZERO, NHALF, ZERO);
    set_cf(2, 0, HALF, ZERO, ZERO, ZERO, ZERO);
    set_cf(3, 0, MAXC, ZERO, ZERO, ZERO, ZERO);
    set_cf(4, 0, QTR, HALF, QTR, NHALF, EIGHTH);
    set_cf(4, 1, HALF, NQTR, EIGHTH, QTR, NEIGHTH);
    clear_hist();

    repeat (3) step(1'b1, 32'sh7FFF_FFFF);
    repeat (3) step(1'b0, 32'sd0);
    step(1'b0, 32'sd1000);
    repeat (4) step(1'b0, 32'sd0);
    repeat (3) step(1'b0, 32'sd3);
    repeat (3) step(1'b0, -32'sd3);
    repeat (3) step(1'b0, 32'sd0);
    repeat (8) step(1'b0, 32'sd1024);
    step(1'b1, 32'sd1024);
    repeat (8) step(1'b0, 32'sd1024);
    repeat (3) step(1'b0, 32'sh7000_0000);
    repeat (3) step(1'b0, 32'sd0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, smp_t'($urandom));
      end else if (r < 30) begin
        step(1'b0, smp_t'($urandom));
      end else begin
        v = smp_t'($urandom_range(32'd0, 32'd2097151));
        step(1'b0, v - 32'sd1048576);
      end
    end
    repeat (3) step(1'b0, 32'sd0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
